fir_mac_sequencer: RTL
======================

Name: fir_mac_sequencer

Overview:
- Parametrised successor to the FIR coefficient/sample address sequencer; computes one filter output per accepted input sample.
- Sits between the sample source and the output stage.
- Drives an external coefficient ROM and an external circular sample RAM, both with 1-cycle synchronous reads.
- Performs the multiply-accumulate internally, then rounds and saturates the result.
- Adds valid/ready handshakes, ring-buffer addressing and zero-initialisation of sample history.

Parameters:
NTAPS, 61, number of taps (2..2^ADDR_W)
ADDR_W, 7, ROM/RAM address width
DATA_W, 16, signed sample width
COEF_W, 16, signed coefficient width
ACC_W, 40, accumulator width; must be >= DATA_W+COEF_W+clog2(NTAPS)
OUT_W, 16, signed output width
OUT_SHIFT, 15, arithmetic right shift applied to accumulator before saturation

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low reset
in_valid  in  1  input sample valid
in_ready  out  1  block can accept a sample
in_data  in  DATA_W  signed input sample
coef_addr  out  ADDR_W  ROM address
coef_rd  out  1  ROM read enable
coef_data  in  COEF_W  ROM data, valid 1 cycle after coef_rd
smp_addr  out  ADDR_W  RAM address
smp_wr  out  1  RAM write enable
smp_wdata  out  DATA_W  RAM write data
smp_rd  out  1  RAM read enable
smp_data  in  DATA_W  RAM data, valid 1 cycle after smp_rd
out_valid  out  1  output valid
out_ready  in  1  downstream accepts output
out_data  out  OUT_W  signed filter output
busy  out  1  high in every state except IDLE
ovf  out  1  sticky saturation flag

Behaviour:
- Reset low at a clock edge:
  - All outputs become 0.
  - State becomes INIT; init counter, wr_ptr and accumulator clear; ovf clears.
  - Applies from any state, including mid-MAC or OUTPUT; any pending output is discarded.
- INIT (NTAPS cycles):
  - smp_wr=1, smp_wdata=0, smp_addr=0..NTAPS-1; busy=1; in_ready=0.
  - Then go to IDLE.
- IDLE:
  - in_ready=1, busy=0; all memory strobes 0.
  - On in_valid&in_ready: capture in_data and go to WRITE.
- WRITE (1 cycle):
  - smp_wr=1, smp_addr=wr_ptr, smp_wdata=captured sample.
  - Accumulator clears; k=0.
- MAC (NTAPS cycles, k=0..NTAPS-1):
  - coef_rd=1, smp_rd=1, coef_addr=k, smp_addr=(wr_ptr-k) mod NTAPS.
  - Wrap rule: if wr_ptr<k, address = wr_ptr+NTAPS-k. No address ever reaches NTAPS or above.
  - From the second MAC cycle onward: acc += sext(coef_data*smp_data). The product is full width DATA_W+COEF_W, signed.
- FLUSH (1 cycle):
  - Accumulate the last product; no memory strobes.
- Result register, loaded on FLUSH exit:
  - r = acc >>> OUT_SHIFT (arithmetic, truncating).
  - If r > 2^(OUT_W-1)-1: out_data = max and ovf=1.
  - If r < -2^(OUT_W-1): out_data = min and ovf=1.
  - Otherwise out_data = r[OUT_W-1:0].
- OUTPUT:
  - out_valid=1; out_data held stable until out_ready.
  - On out_valid&out_ready: wr_ptr = (wr_ptr==NTAPS-1) ? 0 : wr_ptr+1, then go to IDLE.
  - in_valid is ignored while not in IDLE.
- Timing:
  - Input accepted at cycle 0 → out_valid first high at cycle NTAPS+3.
  - Minimum sample period is NTAPS+4 cycles.
- No accumulator overflow detection; guaranteed by the ACC_W constraint.
- ovf clears only on reset.
- out_data keeps its last value after the handshake.
- Transitions: INIT→IDLE→WRITE→MAC→FLUSH→OUTPUT→IDLE; any state→INIT on reset.

Test Plan:
- Reset release, NTAPS=8 → 8 cycles of smp_wr=1 with addresses 0..7 and wdata 0, busy=1; then in_ready=1, busy=0, ovf=0.
- Impulse, NTAPS=8, OUT_SHIFT=0, ROM h[k]=k+1, inputs 1,0,0,…(9 samples) → out_data 1,2,…,8 then 0; out_valid first high exactly 11 cycles after the first in handshake.
- Ring wrap, NTAPS=8, OUT_SHIFT=0, h[k]=1, 20 samples of 100 → outputs 100,200,…,800 then 800 steady; smp_wr address goes 7→0; MAC smp_addr sequence wraps with no value ≥8.
- Saturation, defaults with NTAPS=8, h[k]=32767, inputs 32767 → out_data=32767, ovf=1; reset, then inputs -32768 with h=32767 → out_data=-32768, ovf=1; after reset ovf=0.
- Backpressure: hold out_ready=0 for 10 cycles in OUTPUT while toggling in_valid → out_data stable, in_ready=0, no sample captured; out_ready=1 → single handshake, IDLE next cycle.
- Reset mid-MAC at k=3 → all outputs 0 next edge, INIT re-zeroes the RAM; the next impulse response equals the clean-start impulse-response result.

Source files
------------

// File: rtl/fir_mac_sequencer_if.sv
// Handshake and memory bus of the FIR MAC sequencer: sample in, result out,
// coefficient ROM and circular sample RAM (both with 1-cycle synchronous reads).
interface fir_mac_sequencer_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int OUT_W  = 16
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data;
  logic [ADDR_W-1:0]        coef_addr;
  logic                     coef_rd;
  logic signed [COEF_W-1:0] coef_data;
  logic [ADDR_W-1:0]        smp_addr;
  logic                     smp_wr;
  logic signed [DATA_W-1:0] smp_wdata;
  logic                     smp_rd;
  logic signed [DATA_W-1:0] smp_data;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [OUT_W-1:0]  out_data;
  logic                     busy;
  logic                     ovf;

  modport master (
    input  in_valid, in_data, coef_data, smp_data, out_ready,
    output in_ready, coef_addr, coef_rd, smp_addr, smp_wr, smp_wdata, smp_rd,
           out_valid, out_data, busy, ovf
  );

  modport slave (
    output in_valid, in_data, coef_data, smp_data, out_ready,
    input  in_ready, coef_addr, coef_rd, smp_addr, smp_wr, smp_wdata, smp_rd,
           out_valid, out_data, busy, ovf
  );
endinterface

// File: rtl/fir_mac_sequencer.sv
// FIR filter sequencer: one output per accepted sample, MAC over a circular
// sample RAM and coefficient ROM, followed by shift, saturation and handshake.
module fir_mac_sequencer #(
  parameter int NTAPS     = 61,
  parameter int ADDR_W    = 7,
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int ACC_W     = 40,
  parameter int OUT_W     = 16,
  parameter int OUT_SHIFT = 15
) (
  input logic                clk,
  input logic                reset,
  fir_mac_sequencer_if.master bus
);
  localparam int PROD_W = DATA_W + COEF_W;

  localparam logic [2:0] S_INIT   = 3'd0;
  localparam logic [2:0] S_IDLE   = 3'd1;
  localparam logic [2:0] S_WRITE  = 3'd2;
  localparam logic [2:0] S_MAC    = 3'd3;
  localparam logic [2:0] S_FLUSH  = 3'd4;
  localparam logic [2:0] S_OUTPUT = 3'd5;

  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(NTAPS - 1);
  localparam logic [ADDR_W:0]   NTAPS_X = (ADDR_W + 1)'(NTAPS);

  localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OUT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic [2:0]               state;
  logic                     live;    // low for the cycle(s) the reset edge is applied
  logic [ADDR_W-1:0]        cnt;     // INIT address, then tap index k in MAC
  logic [ADDR_W-1:0]        wr_ptr;
  logic signed [DATA_W-1:0] sample;
  logic signed [ACC_W-1:0]  acc;
  logic signed [OUT_W-1:0]  out_q;
  logic                     ovf_q;

  logic signed [PROD_W-1:0] coef_ext, smp_ext, prod;
  logic signed [ACC_W-1:0]  acc_sum, shifted;
  logic signed [OUT_W-1:0]  sat_val;
  logic                     sat_hit;
  logic [ADDR_W:0]          wrap_sum;
  logic [ADDR_W-1:0]        rd_addr;

  // Full-width signed product, sign-extended into the accumulator.
  assign coef_ext = {{DATA_W{bus.coef_data[COEF_W-1]}}, bus.coef_data};
  assign smp_ext  = {{COEF_W{bus.smp_data[DATA_W-1]}}, bus.smp_data};
  assign prod     = coef_ext * smp_ext;
  assign acc_sum  = acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
  assign shifted  = acc_sum >>> OUT_SHIFT;

  always_comb begin
    sat_hit = 1'b0;
    sat_val = shifted[OUT_W-1:0];
    if (shifted > OUT_MAX) begin
      sat_val = {1'b0, {(OUT_W-1){1'b1}}};
      sat_hit = 1'b1;
    end else if (shifted < OUT_MIN) begin
      sat_val = {1'b1, {(OUT_W-1){1'b0}}};
      sat_hit = 1'b1;
    end
  end

  // Newest sample sits at wr_ptr; tap k reads k entries back, wrapping below 0.
  assign wrap_sum = {1'b0, wr_ptr} + NTAPS_X - {1'b0, cnt};
  assign rd_addr  = (wr_ptr >= cnt) ? (wr_ptr - cnt) : wrap_sum[ADDR_W-1:0];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= S_INIT;
      live   <= 1'b0;
      cnt    <= '0;
      wr_ptr <= '0;
      sample <= '0;
      acc    <= '0;
      out_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      live <= 1'b1;
      case (state)
        S_INIT: begin
          if (live) begin
            if (cnt == LAST) begin
              cnt   <= '0;
              state <= S_IDLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_IDLE: begin
          if (bus.in_valid) begin
            sample <= bus.in_data;
            state  <= S_WRITE;
          end
        end
        S_WRITE: begin
          acc   <= '0;
          cnt   <= '0;
          state <= S_MAC;
        end
        S_MAC: begin
          // Read data lags the address by one cycle, so tap 0 lands on k=1.
          if (cnt != '0) acc <= acc_sum;
          if (cnt == LAST) state <= S_FLUSH;
          else             cnt   <= cnt + 1'b1;
        end
        S_FLUSH: begin
          acc   <= acc_sum;
          out_q <= sat_val;
          if (sat_hit) ovf_q <= 1'b1;
          state <= S_OUTPUT;
        end
        S_OUTPUT: begin
          if (bus.out_ready) begin
            wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            state  <= S_IDLE;
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.busy      = 1'b0;
    bus.coef_rd   = 1'b0;
    bus.coef_addr = '0;
    bus.smp_rd    = 1'b0;
    bus.smp_wr    = 1'b0;
    bus.smp_addr  = '0;
    bus.smp_wdata = '0;
    bus.out_valid = 1'b0;
    bus.out_data  = out_q;
    bus.ovf       = ovf_q;
    if (live) begin
      case (state)
        S_INIT: begin
          bus.busy     = 1'b1;
          bus.smp_wr   = 1'b1;
          bus.smp_addr = cnt;
        end
        S_IDLE: bus.in_ready = 1'b1;
        S_WRITE: begin
          bus.busy      = 1'b1;
          bus.smp_wr    = 1'b1;
          bus.smp_addr  = wr_ptr;
          bus.smp_wdata = sample;
        end
        S_MAC: begin
          bus.busy      = 1'b1;
          bus.coef_rd   = 1'b1;
          bus.coef_addr = cnt;
          bus.smp_rd    = 1'b1;
          bus.smp_addr  = rd_addr;
        end
        S_FLUSH: bus.busy = 1'b1;
        S_OUTPUT: begin
          bus.busy      = 1'b1;
          bus.out_valid = 1'b1;
        end
        default: bus.busy = 1'b1;
      endcase
    end
  end
endmodule
